// File: rtl/project_types.sv
// ---------------------------------------------------------------------------
// project_types
// Shared types and constants for the MIPS pipeline.
//   inst_data_t      : 32-bit instruction word returned by instruction memory
//   inst_addr_t      : 32-bit instruction byte address
//   CHIP_ENABLE/     : levels driven on the instruction-memory enable
//   CHIP_DISABLE
//   INST_BYTES       : byte stride between sequential instructions
//   if_id_t          : IF/ID pipeline register contents
// ---------------------------------------------------------------------------
package project_types;

    typedef logic [31:0] inst_data_t;
    typedef logic [31:0] inst_addr_t;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        inst_addr_t pc;
        inst_data_t inst;
        logic       valid;
        logic       adel;
    } if_id_t;

endpackage

// File: rtl/i_fetch_inst.sv
// ---------------------------------------------------------------------------
// i_fetch_inst
// Instruction-fetch handshake between the IF stage and instruction memory.
//   en   : chip enable (CHIP_ENABLE / CHIP_DISABLE), driven by master
//   addr : instruction byte address, driven by master
//   data : instruction word, returned combinationally by slave
// ---------------------------------------------------------------------------
interface i_fetch_inst;
    import project_types::*;

    logic       en;
    inst_addr_t addr;
    inst_data_t data;

    modport master (output en, output addr, input  data);
    modport slave  (input  en, input  addr, output data);
endinterface

// File: rtl/pc_fetch_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
// Priority on each rising edge: reset > flush (bubble) > stall (hold) > capture.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset
//   i_stall  in  : hold contents
//   i_flush  in  : replace contents with a bubble
//   i_d      in  : value to capture (if_id_t)
//   o_q      out : registered IF/ID contents (if_id_t)
// ---------------------------------------------------------------------------
module if_id_reg
    import project_types::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_stall,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (!i_stall) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// handshake and loads the returned word into the IF/ID register.
//   RESET_PC       param : first fetch address after reset
//   clk            in    : clock
//   rst            in    : synchronous active-high reset
//   fetch          if    : i_fetch_inst.master (en, addr out; data in)
//   stall          in    : hold PC and IF/ID
//   flush          in    : redirect to flush_pc, bubble into IF/ID
//   flush_pc       in    : flush redirect target
//   branch_flag    in    : taken branch from ID (delay slot is kept)
//   branch_target  in    : branch redirect target
//   if_pc          out   : PC of instruction in IF/ID
//   if_inst        out   : instruction word in IF/ID
//   if_valid       out   : IF/ID holds a real instruction
//   if_adel        out   : address error on fetch
// Build option: FETCH_ALIGN_CHECK_EN - suppress fetches from misaligned PCs
// and flag them via if_adel; when undefined if_adel stays 0.
// ---------------------------------------------------------------------------
module pc_fetch
    import project_types::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    i_fetch_inst.master fetch,
    input  logic        stall,
    input  logic        flush,
    input  inst_addr_t  flush_pc,
    input  logic        branch_flag,
    input  inst_addr_t  branch_target,
    output inst_addr_t  if_pc,
    output inst_data_t  if_inst,
    output logic        if_valid,
    output logic        if_adel
);

    logic       r_ce;
    inst_addr_t r_pc;
    logic       w_misaligned;
    if_id_t     w_if_id_d;
    if_id_t     w_if_id_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = r_ce && (r_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Enable and address depend only on registered state.
    assign fetch.en   = (r_ce && !w_misaligned) ? CHIP_ENABLE : CHIP_DISABLE;
    assign fetch.addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce <= 1'b0;
            r_pc <= RESET_PC;
        end else begin
            r_ce <= 1'b1;
            if (r_ce) begin
                if (flush) begin
                    r_pc <= flush_pc;
                end else if (stall) begin
                    r_pc <= r_pc;
                end else if (branch_flag) begin
                    r_pc <= branch_target;
                end else begin
                    r_pc <= r_pc + inst_addr_t'(INST_BYTES);
                end
            end
        end
    end

    // Before the first fetch the register is fed a bubble.
    always_comb begin
        w_if_id_d = '0;
        if (r_ce) begin
            w_if_id_d.pc    = r_pc;
            w_if_id_d.inst  = w_misaligned ? '0 : fetch.data;
            w_if_id_d.valid = 1'b1;
            w_if_id_d.adel  = w_misaligned;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_stall (stall),
        .i_flush (flush),
        .i_d     (w_if_id_d),
        .o_q     (w_if_id_q)
    );

    assign if_pc    = w_if_id_q.pc;
    assign if_inst  = w_if_id_q.inst;
    assign if_valid = w_if_id_q.valid;
    assign if_adel  = w_if_id_q.adel;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Scoreboard bench for pc_fetch with RESET_PC = 32'hBFC0_0000. A driver
// applies one directed input vector per cycle and queues the hand-computed
// state expected after that edge; a monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch;
    import project_types::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    inst_addr_t flush_pc = '0;
    logic       branch_flag = 1'b0;
    inst_addr_t branch_target = '0;
    inst_addr_t if_pc;
    inst_data_t if_inst;
    logic       if_valid;
    logic       if_adel;

    i_fetch_inst fetch_if ();

    always #5 clk = ~clk;

    function automatic inst_data_t mem_word(input inst_addr_t a);
        return {a[7:0], a[31:8]} ^ 32'h2400_0001;
    endfunction

    // Instruction memory answers combinationally.
    assign fetch_if.data = mem_word(fetch_if.addr);

    pc_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch         (fetch_if.master),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .if_adel       (if_adel)
    );

    typedef struct {
        string      name;
        logic       en;
        inst_addr_t addr;
        inst_addr_t pc;
        inst_data_t inst;
        logic       valid;
        logic       adel;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Monitor: compare the post-edge state against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (fetch_if.en === e.en && fetch_if.addr === e.addr &&
                    if_pc === e.pc && if_inst === e.inst &&
                    if_valid === e.valid && if_adel === e.adel) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got en=%0b addr=%h pc=%h inst=%h v=%0b adel=%0b, want en=%0b addr=%h pc=%h inst=%h v=%0b adel=%0b",
                             e.name, fetch_if.en, fetch_if.addr, if_pc, if_inst, if_valid, if_adel,
                             e.en, e.addr, e.pc, e.inst, e.valid, e.adel);
                end
            end
        end
    end

    task automatic cyc(input string name, input logic r, input logic s, input logic f,
                       input inst_addr_t fpc, input logic b, input inst_addr_t bt,
                       input logic en, input inst_addr_t addr, input inst_addr_t pc,
                       input logic v, input logic adel);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; flush_pc = fpc;
        branch_flag = b; branch_target = bt;
        e.name  = name;
        e.en    = en;
        e.addr  = addr;
        e.pc    = pc;
        e.inst  = (v && !adel) ? mem_word(pc) : '0;
        e.valid = v;
        e.adel  = adel;
        q.push_back(e);
    endtask

    localparam inst_addr_t RP = 32'hBFC0_0000;

    initial begin
        //  name          rst stl fl  fpc           br  bt            en    addr          if_pc         v     adel
        cyc("reset0",     1, 0, 0, '0,           0, '0,           1'b0, RP,           '0,           1'b0, 1'b0);
        cyc("reset1",     1, 0, 0, '0,           0, '0,           1'b0, RP,           '0,           1'b0, 1'b0);
        cyc("reset2",     1, 0, 0, '0,           0, '0,           1'b0, RP,           '0,           1'b0, 1'b0);
        cyc("ce_on",      0, 0, 0, '0,           0, '0,           1'b1, RP,           '0,           1'b0, 1'b0);
        cyc("first",      0, 0, 0, '0,           0, '0,           1'b1, RP + 4,       RP,           1'b1, 1'b0);
        cyc("seq4",       0, 0, 0, '0,           0, '0,           1'b1, RP + 8,       RP + 4,       1'b1, 1'b0);
        cyc("seq8",       0, 0, 0, '0,           0, '0,           1'b1, RP + 12,      RP + 8,       1'b1, 1'b0);
        cyc("flush0",     0, 0, 1, 32'h0,        0, '0,           1'b1, 32'h0,        '0,           1'b0, 1'b0);
        cyc("pc0",        0, 0, 0, '0,           0, '0,           1'b1, 32'h4,        32'h0,        1'b1, 1'b0);
        cyc("pc4",        0, 0, 0, '0,           0, '0,           1'b1, 32'h8,        32'h4,        1'b1, 1'b0);
        cyc("pc8",        0, 0, 0, '0,           0, '0,           1'b1, 32'hC,        32'h8,        1'b1, 1'b0);
        cyc("br_slot",    0, 0, 0, '0,           1, 32'h40,       1'b1, 32'h40,       32'hC,        1'b1, 1'b0);
        cyc("br_tgt",     0, 0, 0, '0,           0, '0,           1'b1, 32'h44,       32'h40,       1'b1, 1'b0);
        cyc("flush_stl",  0, 1, 1, 32'h180,      0, '0,           1'b1, 32'h180,      '0,           1'b0, 1'b0);
        cyc("flush_tgt",  0, 0, 0, '0,           0, '0,           1'b1, 32'h184,      32'h180,      1'b1, 1'b0);
        cyc("flush_nxt",  0, 0, 0, '0,           0, '0,           1'b1, 32'h188,      32'h184,      1'b1, 1'b0);
        cyc("to_1c",      0, 0, 1, 32'h1C,       0, '0,           1'b1, 32'h1C,       '0,           1'b0, 1'b0);
        cyc("pc1c",       0, 0, 0, '0,           0, '0,           1'b1, 32'h20,       32'h1C,       1'b1, 1'b0);
        cyc("stall1",     0, 1, 0, '0,           1, 32'h300,      1'b1, 32'h20,       32'h1C,       1'b1, 1'b0);
        cyc("stall2",     0, 1, 0, '0,           1, 32'h300,      1'b1, 32'h20,       32'h1C,       1'b1, 1'b0);
        cyc("stall3",     0, 1, 0, '0,           1, 32'h300,      1'b1, 32'h20,       32'h1C,       1'b1, 1'b0);
        cyc("stall_br",   0, 0, 0, '0,           1, 32'h300,      1'b1, 32'h300,      32'h20,       1'b1, 1'b0);
        cyc("stall_tgt",  0, 0, 0, '0,           0, '0,           1'b1, 32'h304,      32'h300,      1'b1, 1'b0);
        cyc("wrap_fl",    0, 0, 1, 32'hFFFF_FFFC, 0, '0,          1'b1, 32'hFFFF_FFFC, '0,          1'b0, 1'b0);
        cyc("wrap_top",   0, 0, 0, '0,           0, '0,           1'b1, 32'h0,        32'hFFFF_FFFC, 1'b1, 1'b0);
        cyc("wrap_zero",  0, 0, 0, '0,           0, '0,           1'b1, 32'h4,        32'h0,        1'b1, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        cyc("mis_slot",   0, 0, 0, '0,           1, 32'h42,       1'b0, 32'h42,       32'h4,        1'b1, 1'b0);
        cyc("mis_adel",   0, 0, 0, '0,           0, '0,           1'b0, 32'h46,       32'h42,       1'b1, 1'b1);
`else
        cyc("mis_slot",   0, 0, 0, '0,           1, 32'h42,       1'b1, 32'h42,       32'h4,        1'b1, 1'b0);
        cyc("mis_noadel", 0, 0, 0, '0,           0, '0,           1'b1, 32'h46,       32'h42,       1'b1, 1'b0);
`endif
        cyc("mis_flush",  0, 0, 1, 32'h0,        0, '0,           1'b1, 32'h0,        '0,           1'b0, 1'b0);
        cyc("post_fl",    0, 0, 0, '0,           0, '0,           1'b1, 32'h4,        32'h0,        1'b1, 1'b0);
        cyc("rerst",      1, 0, 0, '0,           0, '0,           1'b0, RP,           '0,           1'b0, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
